// File: rtl/sobel_x_row_scheduler.sv
// Row-read scheduler for a 3x3 Sobel-X PE column: streams frame rows out of the
// line memory and flags PE outputs whose 3-row window lies entirely inside the frame.
module sobel_x_row_scheduler #(
    parameter int ROW_AW = 10,
    parameter int H_W    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ROW_AW-1:0] cfg_base,
    input  logic [H_W-1:0]    cfg_height,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_rd_en,
    output logic [ROW_AW-1:0] mem_rd_addr,
    output logic              out_valid,
    output logic [H_W-1:0]    out_row,
    output logic              out_last
);

    localparam int STAGES = 3;

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t                        state;
    logic [H_W-1:0]                height_q;
    logic [H_W-1:0]                rd_row;
    logic [1:0]                    drain_cnt;
    logic [STAGES-1:0]             vld_pipe;
    logic [STAGES-1:0]             last_pipe;
    logic [STAGES-1:0][H_W-1:0]    row_pipe;

    assign busy      = (state != IDLE);
    assign out_valid = vld_pipe[STAGES-1];
    assign out_last  = last_pipe[STAGES-1];
    assign out_row   = row_pipe[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            height_q    <= '0;
            rd_row      <= '0;
            drain_cnt   <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                mem_rd_en <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (cfg_height >= H_W'(3)) begin
                                state       <= FEED;
                                height_q    <= cfg_height;
                                rd_row      <= '0;
                                mem_rd_en   <= 1'b1;
                                mem_rd_addr <= cfg_base;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    FEED: begin
                        // The read presented this cycle is for rd_row; stop after row H-1.
                        if (rd_row == height_q - H_W'(1)) begin
                            state     <= DRAIN;
                            mem_rd_en <= 1'b0;
                            drain_cnt <= '0;
                        end else begin
                            rd_row      <= rd_row + H_W'(1);
                            mem_rd_addr <= mem_rd_addr + ROW_AW'(1);
                        end
                    end
                    DRAIN: begin
                        drain_cnt <= drain_cnt + 2'd1;
                        if (drain_cnt == 2'd2) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Delay line matches memory latency + vertical add + horizontal subtract.
    // A read of row r completes the window centred on r-1, valid only for r >= 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            row_pipe  <= '0;
        end else if (abort) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            row_pipe  <= '0;
        end else begin
            vld_pipe[0]  <= mem_rd_en && (rd_row >= H_W'(2));
            last_pipe[0] <= mem_rd_en && (rd_row == height_q - H_W'(1));
            row_pipe[0]  <= rd_row - H_W'(1);
            for (int i = 1; i < STAGES; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
                row_pipe[i]  <= row_pipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_sobel_x_row_scheduler.sv
// Directed bench for sobel_x_row_scheduler: frame timing, wrap, illegal height,
// abort, mid-frame reset and ignored starts.
module tb_sobel_x_row_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [9:0] cfg_base = '0;
    logic [9:0] cfg_height = '0;
    logic       busy, done, err, mem_rd_en, out_valid, out_last;
    logic [9:0] mem_rd_addr, out_row;

    int checks = 0;
    int failures = 0;

    sobel_x_row_scheduler #(.ROW_AW(10), .H_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_base(cfg_base), .cfg_height(cfg_height),
        .busy(busy), .done(done), .err(err),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .out_valid(out_valid), .out_row(out_row), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".err"}, err, 0);
        chk({tag, ".rd_en"}, mem_rd_en, 0);
        chk({tag, ".addr"}, mem_rd_addr, 0);
        chk({tag, ".valid"}, out_valid, 0);
        chk({tag, ".row"}, out_row, 0);
        chk({tag, ".last"}, out_last, 0);
    endtask

    // Runs one frame from IDLE, checking every cycle s+1..s+h+5 against the
    // frame timeline. poke>0 drives an illegal start in that cycle mid-frame.
    task automatic run_frame(input logic [9:0] base, input int h, input int poke);
        logic [9:0] exp_addr;
        cfg_base = base;
        cfg_height = 10'(h);
        start = 1'b1;
        step();
        start = 1'b0;
        cfg_height = 10'd2;
        for (int k = 1; k <= h + 5; k++) begin
            chk($sformatf("h%0d.k%0d.busy", h, k), busy, (k <= h + 4));
            chk($sformatf("h%0d.k%0d.rd_en", h, k), mem_rd_en, (k <= h));
            if (k <= h) begin
                exp_addr = base + 10'(k - 1);
                chk($sformatf("h%0d.k%0d.addr", h, k), mem_rd_addr, exp_addr);
            end
            chk($sformatf("h%0d.k%0d.valid", h, k), out_valid, (k >= 6 && k <= h + 3));
            if (k >= 6 && k <= h + 3)
                chk($sformatf("h%0d.k%0d.row", h, k), out_row, k - 5);
            chk($sformatf("h%0d.k%0d.last", h, k), out_last, (k == h + 3));
            chk($sformatf("h%0d.k%0d.done", h, k), done, (k == h + 4));
            chk($sformatf("h%0d.k%0d.err", h, k), err, 0);
            if (k == poke) start = 1'b1;
            step();
            start = 1'b0;
        end
    endtask

    initial begin
        #3;
        chk_all_zero("reset");
        step();
        chk_all_zero("reset_edge");
        rst_n = 1'b1;

        // Height 5, base 0x010, with an illegal start poked mid-frame.
        run_frame(10'h010, 5, 3);

        // Height 3: single valid row that is also last.
        run_frame(10'h000, 3, 0);

        // Illegal height 2: one-cycle err, nothing else moves.
        cfg_height = 10'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("h2.err", err, 1);
        chk("h2.busy", busy, 0);
        chk("h2.rd_en", mem_rd_en, 0);
        chk("h2.valid", out_valid, 0);
        step();
        chk("h2.err_clr", err, 0);
        chk("h2.busy2", busy, 0);

        // Address wrap at the top of the line memory.
        run_frame(10'h3FE, 4, 0);

        // abort + start together in IDLE: nothing is accepted.
        cfg_height = 10'd5;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("abst.busy", busy, 0);
        chk("abst.rd_en", mem_rd_en, 0);
        chk("abst.err", err, 0);

        // Height 8, abort at s+7.
        cfg_base = 10'h100;
        cfg_height = 10'd8;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 7; k++) step();
        chk("abort.s7.valid", out_valid, 1);
        chk("abort.s7.row", out_row, 2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort.s8.valid", out_valid, 0);
        chk("abort.s8.busy", busy, 0);
        chk("abort.s8.rd_en", mem_rd_en, 0);
        chk("abort.s8.done", done, 0);
        step();
        chk("abort.s9.valid", out_valid, 0);
        chk("abort.s9.done", done, 0);
        // New frame at s+9; stale pipeline must not leak into it.
        run_frame(10'h020, 3, 0);

        // Reset pulled at s+4 of a height-8 frame.
        cfg_base = 10'h055;
        cfg_height = 10'd8;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 4; k++) step();
        chk("rst.s4.busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst.async");
        step();
        chk_all_zero("rst.held");
        rst_n = 1'b1;
        run_frame(10'h200, 4, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
